// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch: FSM encoding,
// blank segment pattern and BCD digit width.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam int         BCD_W     = 4;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder, segment order {g,f,e,d,c,b,a}.
// Codes 10..15 blank the digit.
module bcd_to_seg7
  import stopwatch_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [6:0]       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = 7'h40;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_bcd_mux.sv
// Multi-digit BCD stopwatch with start/pause/clear FSM and scanned active-low 7-seg output.
// Define STOPWATCH_LAP_EN to add a lap-hold display freeze driven by the lap pulse.
module stopwatch_bcd_mux
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ         = 100000000,
  parameter int TICK_HZ        = 100,
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  lap,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            segment,
  output logic                  running,
  output logic                  overflow
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = NUM_DIGITS * BCD_W;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q;
  logic [CNT_W-1:0]   count_q, count_inc, disp_count;
  logic [REF_W-1:0]   refresh_q;
  logic [IDX_W-1:0]   scan_idx_q;
  logic [BCD_W-1:0]   sel_digit;
  logic [6:0]         seg_dec;
  logic               tick, all_nines, clear_cnt;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !stop) state_d = RUN;
      RUN:     if (stop) state_d = PAUSE;
      PAUSE: begin
        if (stop)       state_d = IDLE;
        else if (start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  assign running   = (state_q == RUN);
  assign tick      = running && (div_q == DIV_LAST);
  assign clear_cnt = (state_q == PAUSE) && stop;

  // Ripple the increment through the digits; carry surviving all digits means all-9s.
  always_comb begin
    logic carry;
    carry     = 1'b1;
    count_inc = count_q;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (carry) begin
        if (count_q[k*BCD_W +: BCD_W] == BCD_W'(9)) begin
          count_inc[k*BCD_W +: BCD_W] = '0;
        end else begin
          count_inc[k*BCD_W +: BCD_W] = count_q[k*BCD_W +: BCD_W] + BCD_W'(1);
          carry = 1'b0;
        end
      end
    end
    all_nines = carry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      overflow <= tick && all_nines;
      // The divider holds through PAUSE so partial tick periods survive a pause.
      if (running)
        div_q <= tick ? '0 : div_q + DIV_W'(1);
      else if (state_d == IDLE)
        div_q <= '0;
      if (clear_cnt)
        count_q <= '0;
      else if (tick)
        count_q <= count_inc;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic             held_q;
  logic [CNT_W-1:0] hold_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      held_q <= 1'b0;
      hold_q <= '0;
    end else if (state_d == IDLE) begin
      held_q <= 1'b0;
    end else if (running && lap && !stop) begin
      held_q <= !held_q;
      if (!held_q) hold_q <= count_q;
    end
  end

  assign disp_count = held_q ? hold_q : count_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign disp_count = count_q;
`endif

  always_comb begin
    sel_digit = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (scan_idx_q == IDX_W'(k)) sel_digit = disp_count[k*BCD_W +: BCD_W];
    end
  end

  bcd_to_seg7 u_dec (
    .bcd (sel_digit),
    .seg (seg_dec)
  );

  // Scan stage: an/segment are registered from the current index, so they trail it by one clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_q  <= '0;
      scan_idx_q <= '0;
      an         <= '1;
      segment    <= SEG_BLANK;
    end else begin
      if (refresh_q == REF_LAST) begin
        refresh_q  <= '0;
        scan_idx_q <= (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IDX_W'(1);
      end else begin
        refresh_q <= refresh_q + REF_W'(1);
      end
      an      <= ~(NUM_DIGITS'(1) << scan_idx_q);
      segment <= seg_dec;
    end
  end

endmodule

// File: tb/tb_stopwatch_bcd_mux.sv
// Self-checking bench for stopwatch_bcd_mux (10-clock tick, 2 digits, 4-clock refresh);
// the lap scenario follows STOPWATCH_LAP_EN.
module tb_stopwatch_bcd_mux;

  logic       clk;
  logic       reset, start, stop, lap;
  logic [1:0] an;
  logic [6:0] segment;
  logic       running, overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int exp_q[$];

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  stopwatch_bcd_mux #(
    .CLK_HZ         (20),
    .TICK_HZ        (2),
    .NUM_DIGITS     (2),
    .REFRESH_CYCLES (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .lap      (lap),
    .an       (an),
    .segment  (segment),
    .running  (running),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int seg_to_digit(input logic [6:0] s);
    for (int d = 0; d < 10; d++) if (s === seg_tab[d]) return d;
    return -1;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic s, input logic p, input logic l);
    start = s; stop = p; lap = l;
    step(1);
    start = 1'b0; stop = 1'b0; lap = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  // Pops the next expected count and reads both digits off the scanned display.
  task automatic check_display(input string name);
    int  expv, d0, d1, got;
    bit  g0, g1;
    expv = exp_q.pop_front();
    g0 = 0; g1 = 0; d0 = -1; d1 = -1;
    for (int i = 0; i < 40 && !(g0 && g1); i++) begin
      step(1);
      if (an === 2'b10)      begin d0 = seg_to_digit(segment); g0 = 1; end
      else if (an === 2'b01) begin d1 = seg_to_digit(segment); g1 = 1; end
    end
    n_tests++;
    if (!(g0 && g1)) begin
      n_fail++;
      $display("FAIL %s: scan timeout, digits seen d0=%0b d1=%0b, expected %0d", name, g0, g1, expv);
    end else begin
      got = (d0 < 0 || d1 < 0) ? -1 : d1 * 10 + d0;
      if (got !== expv) begin
        n_fail++;
        $display("FAIL %s: display %0d, expected %0d", name, got, expv);
      end
    end
  endtask

  task automatic test_reset();
    logic [1:0] exp_an;
    reset = 1'b1; start = 1'b0; stop = 1'b0; lap = 1'b0;
    step(3);
    n_tests++;
    if ({an, segment, running, overflow} !== {2'b11, 7'h7F, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: an=%b seg=%h run=%b ovf=%b, expected an=11 seg=7f run=0 ovf=0",
               an, segment, running, overflow);
    end
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step(1);
      exp_an = ((i / 4) % 2 == 0) ? 2'b10 : 2'b01;
      n_tests++;
      if (an !== exp_an || segment !== seg_tab[0]) begin
        n_fail++;
        $display("FAIL scan_after_reset[%0d]: an=%b seg=%h, expected an=%b seg=%h",
                 i, an, segment, exp_an, seg_tab[0]);
      end
    end
  endtask

  task automatic test_run_pause();
    pulse(1, 0, 0);
    n_tests++;
    if (running !== 1'b1) begin
      n_fail++;
      $display("FAIL running_after_start: %b, expected 1", running);
    end
    step(252);
    pulse(0, 1, 0);
    n_tests++;
    if (running !== 1'b0) begin
      n_fail++;
      $display("FAIL running_after_stop: %b, expected 0", running);
    end
    exp_q.push_back(25);
    check_display("count_25");
    step(100);
    exp_q.push_back(25);
    check_display("pause_hold_25");
  endtask

  task automatic test_resume();
    pulse(1, 0, 0);
    step(7);
    pulse(0, 1, 0);
    exp_q.push_back(26);
    check_display("resume_partial_26");
    pulse(0, 1, 0);
    pulse(0, 1, 0);
    n_tests++;
    if (running !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_running: %b, expected 0", running);
    end
    exp_q.push_back(0);
    check_display("clear_to_idle");
  endtask

  task automatic test_overflow();
    int early;
    early = 0;
    pulse(1, 0, 0);
    for (int i = 0; i < 990; i++) begin
      step(1);
      if (overflow !== 1'b0) early++;
    end
    pulse(0, 1, 0);
    exp_q.push_back(99);
    check_display("count_99");
    pulse(1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (overflow !== 1'b0) early++;
    end
    n_tests++;
    if (early !== 0) begin
      n_fail++;
      $display("FAIL overflow_early: %0d high cycles, expected 0", early);
    end
    step(1);
    n_tests++;
    if (overflow !== 1'b1 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_pulse: ovf=%b run=%b, expected ovf=1 run=1", overflow, running);
    end
    step(1);
    n_tests++;
    if (overflow !== 1'b0 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_width: ovf=%b run=%b, expected ovf=0 run=1", overflow, running);
    end
    pulse(0, 1, 0);
    exp_q.push_back(0);
    check_display("wrap_to_00");
  endtask

  task automatic test_same_cycle();
    pulse(1, 0, 0);
    step(25);
    pulse(1, 1, 0);
    n_tests++;
    if (running !== 1'b0) begin
      n_fail++;
      $display("FAIL both_in_run: running=%b, expected 0", running);
    end
    exp_q.push_back(2);
    check_display("both_in_run_count");
    pulse(1, 1, 0);
    exp_q.push_back(0);
    check_display("both_in_pause_clear");
    pulse(1, 1, 0);
    step(20);
    n_tests++;
    if (running !== 1'b0) begin
      n_fail++;
      $display("FAIL both_in_idle: running=%b, expected 0", running);
    end
    exp_q.push_back(0);
    check_display("both_in_idle_count");
  endtask

  task automatic test_scan();
    logic [1:0] prev, first;
    logic [6:0] exp_seg;
    int         len, bad;
    do_reset();
    pulse(1, 0, 0);
    step(470);
    pulse(0, 1, 0);
    exp_q.push_back(47);
    check_display("count_47");
    prev = an;
    for (int i = 0; i < 10 && an === prev; i++) step(1);
    first = an;
    for (int r = 0; r < 4; r++) begin
      prev = an; len = 0; bad = 0;
      while (an === prev && len < 10) begin
        exp_seg = (an === 2'b10) ? seg_tab[7] : seg_tab[4];
        if ((an !== 2'b10 && an !== 2'b01) || segment !== exp_seg) bad++;
        len++;
        step(1);
      end
      n_tests++;
      if (len !== 4 || bad !== 0 || prev !== ((r % 2 == 0) ? first : ~first)) begin
        n_fail++;
        $display("FAIL scan_run[%0d]: an=%b held %0d clocks with %0d bad segs, expected 4 clocks and 0 bad",
                 r, prev, len, bad);
      end
    end
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic test_lap();
    int t0;
    do_reset();
    pulse(1, 0, 0);
    t0 = cyc;
    step(120);
    pulse(0, 0, 1);
    exp_q.push_back(12);
    check_display("lap_frozen_12");
    for (int i = 0; i < 200 && cyc < t0 + 200; i++) step(1);
    pulse(0, 0, 1);
    pulse(0, 1, 0);
    exp_q.push_back(20);
    check_display("lap_release_20");
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    step(15);
    reset = 1'b1;
    step(1);
    n_tests++;
    if (an !== 2'b11 || segment !== 7'h7F || running !== 1'b0) begin
      n_fail++;
      $display("FAIL lap_reset_blank: an=%b seg=%h run=%b, expected an=11 seg=7f run=0",
               an, segment, running);
    end
    reset = 1'b0;
    exp_q.push_back(0);
    check_display("lap_reset_live_00");
  endtask
`else
  task automatic test_lap();
    do_reset();
    pulse(1, 0, 0);
    step(30);
    pulse(0, 0, 1);
    step(89);
    pulse(0, 1, 0);
    exp_q.push_back(12);
    check_display("lap_ignored_12");
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; lap = 1'b0;
    test_reset();
    test_run_pause();
    test_resume();
    test_overflow();
    test_same_cycle();
    test_scan();
    test_lap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
